fft_8pt: RTL and testbench
==========================

FFT_8PT -- requirements
Module: fft_8pt

Interface
REQ-001 clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 real_in  input  12  signed two's-complement real sample to write.
REQ-004 imag_in  input  12  signed two's-complement imaginary sample to write.
REQ-005 addr_real  input  3  real sample-memory write address (time index n).
REQ-006 addr_imag  input  3  imaginary sample-memory write address (time index n).
REQ-007 wr_en_real  input  1  real write enable: re_mem[addr_real] <= real_in at the clock edge.
REQ-008 wr_en_imag  input  1  imaginary write enable: im_mem[addr_imag] <= imag_in at the clock edge.
REQ-009 fft_real_out  output  24  signed real part of the current output bin, registered.
REQ-010 fft_imag_out  output  24  signed imaginary part of the current output bin, registered.
REQ-011 Parameters: none; all widths are fixed.

Function
REQ-012 Two independent 8x12 sample memories; real and imaginary writes are independent and may occur in the same cycle.
REQ-013 FSM states: IDLE, CALC, OUT.
  - IDLE -> CALC at an edge where wr_en_real=1 and addr_real=7.
  - CALC -> OUT after 1 cycle.
  - OUT lasts 8 cycles, then returns to IDLE.
REQ-014 Trigger edge is T0. The address-7 write at T0 is included in the transform.
REQ-015 At edge T1 (CALC), the full transform of the memory contents is registered into eight complex result registers (snapshot).
REQ-016 Writes during CALC or OUT:
  - update memory;
  - do not alter the snapshot;
  - never retrigger; the trigger is recognised only in IDLE.
REQ-017 Bin k (k=0..7, natural order) appears on the outputs from edge T0+2+k.
REQ-018 After bin 7, the outputs hold bin 7 until the next run or reset.
REQ-019 Algorithm: radix-2 decimation-in-time, bit-reversed input order (0,4,2,6,1,5,3,7), natural output order; X[k] = sum over n of x[n]*exp(-j*2*pi*n*k/8).
REQ-020 Twiddles are Q8: W0=(256,0), W1=(181,-181), W2=(0,-256), W3=(-181,-181).
  - Stages 1 and 2 are add/subtract only (W4 = -j realised by swap and negate).
  - Stage 3 multiplies the lower branch by the twiddle.
  - Stage 3 multiplies the upper branch by 256 (shift left 8).
REQ-021 Arithmetic is exact: no rounding, truncation or saturation.
  - Stage-2 values: 14 bits.
  - Stage-3 results: sign-extended into 24 bits.
  - Output equals 256*X[k], with 1/sqrt2 approximated as 181/256.
REQ-022 Overflow is impossible: worst-case |output| < 2^23.

Reset
REQ-023 Reset has priority over writes and the trigger.
REQ-024 Reset clears both memories and all result registers to 0, and forces IDLE.
REQ-025 Reset forces fft_real_out = 0 and fft_imag_out = 0 from the next edge.
REQ-026 Reset in CALC or OUT aborts the run; no further bins are emitted.

Structure
REQ-027 Shared package fft_8pt_pkg holds:
  - widths: IN_W=12, OUT_W=24, TW_FRAC=8;
  - twiddle constants 181 and 256;
  - the FSM state enum.
REQ-028 One sub-module, fft_bfly: a combinational radix-2 complex butterfly with twiddle input; used for all 12 butterflies.

Verification
REQ-029 Impulse: x[0]=1+0j, all other samples 0, trigger -> bins 0..7 = (256,0) each, at T0+2..T0+9.
REQ-030 DC: all real=1, imaginary=0 -> bin 0 = (2048,0); bins 1..7 = (0,0).
REQ-031 Shifted impulse: x[1]=100 real only -> bin0 (25600,0), bin1 (18100,-18100), bin2 (0,-25600), bin3 (-18100,-18100), bin4 (-25600,0).
REQ-032 Extremes: all samples = -2048 - 2048j -> bin 0 = (-4194304,-4194304); others 0; no wrap.
REQ-033 Rewrite and reset cases:
  - Write addr 3 during OUT -> current bins unchanged.
  - Trigger again in IDLE -> new bins reflect the new data.
REQ-034 Assert reset at bin 4 -> outputs 0 on the next edge; state IDLE; memories read back 0 on a following run.

Source files
------------

// File: rtl/fft_8pt_pkg.sv
// Shared widths, Q8 twiddle constants and FSM state type for the 8-point FFT.
package fft_8pt_pkg;

    localparam int IN_W    = 12;
    localparam int S1_W    = 13;
    localparam int S2_W    = 14;
    localparam int OUT_W   = 24;
    localparam int TW_FRAC = 8;
    localparam int TW_W    = 10;
    localparam int TW_ONE  = 256;
    localparam int TW_R2   = 181;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Real part of W8^k in Q8, k = 0..3
    function automatic logic signed [TW_W-1:0] tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return TW_W'(TW_ONE);
            2'd1:    return TW_W'(TW_R2);
            2'd2:    return '0;
            default: return -TW_W'(TW_R2);
        endcase
    endfunction

    // Imaginary part of W8^k in Q8, k = 0..3
    function automatic logic signed [TW_W-1:0] tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return -TW_W'(TW_R2);
            2'd2:    return -TW_W'(TW_ONE);
            default: return -TW_W'(TW_R2);
        endcase
    endfunction

endpackage

// File: rtl/fft_8pt_bfly.sv
// Combinational radix-2 complex butterfly: p = a + W*b, q = a - W*b.
// With MUL=0 only W0 (pass) and W2 (-j, swap and negate) are used, no multiplier.
// With MUL=1 the lower branch is multiplied by the Q8 twiddle and the upper
// branch is scaled by 256 so both share the same Q8 weight.
module fft_bfly
    import fft_8pt_pkg::*;
#(
    parameter int IW  = 12,
    parameter int OW  = 13,
    parameter bit MUL = 1'b0
) (
    input  logic signed [IW-1:0] a_re_i,
    input  logic signed [IW-1:0] a_im_i,
    input  logic signed [IW-1:0] b_re_i,
    input  logic signed [IW-1:0] b_im_i,
    input  logic        [1:0]    tw_i,
    output logic signed [OW-1:0] p_re_o,
    output logic signed [OW-1:0] p_im_o,
    output logic signed [OW-1:0] q_re_o,
    output logic signed [OW-1:0] q_im_o
);

    logic signed [OW-1:0] ar, ai, br, bi, wr, wi, sr, si, tr, ti;

    // Sign-extend operands, apply the twiddle, then add/subtract
    always_comb begin
        ar = OW'(a_re_i);
        ai = OW'(a_im_i);
        br = OW'(b_re_i);
        bi = OW'(b_im_i);
        wr = OW'(tw_re(tw_i));
        wi = OW'(tw_im(tw_i));
        sr = ar;
        si = ai;
        tr = br;
        ti = bi;
        if (MUL) begin
            sr = ar <<< TW_FRAC;
            si = ai <<< TW_FRAC;
            tr = br * wr - bi * wi;
            ti = br * wi + bi * wr;
        end else if (tw_i == 2'd2) begin
            tr = bi;
            ti = -br;
        end
        p_re_o = sr + tr;
        p_im_o = si + ti;
        q_re_o = sr - tr;
        q_im_o = si - ti;
    end

endmodule

// File: rtl/fft_8pt.sv
// 8-point radix-2 DIT FFT: two writable sample memories, a combinational
// three-stage butterfly network, a snapshot of all eight bins, and a
// bin-per-cycle registered output sequence.
module fft_8pt
    import fft_8pt_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  real_in,
    input  logic signed [IN_W-1:0]  imag_in,
    input  logic        [2:0]       addr_real,
    input  logic        [2:0]       addr_imag,
    input  logic                    wr_en_real,
    input  logic                    wr_en_imag,
    output logic signed [OUT_W-1:0] fft_real_out,
    output logic signed [OUT_W-1:0] fft_imag_out
);

    logic signed [IN_W-1:0]  re_mem_q [8];
    logic signed [IN_W-1:0]  im_mem_q [8];
    logic signed [S1_W-1:0]  s1_re [8];
    logic signed [S1_W-1:0]  s1_im [8];
    logic signed [S2_W-1:0]  s2_re [8];
    logic signed [S2_W-1:0]  s2_im [8];
    logic signed [OUT_W-1:0] x_re [8];
    logic signed [OUT_W-1:0] x_im [8];
    logic signed [OUT_W-1:0] res_re_q [8];
    logic signed [OUT_W-1:0] res_im_q [8];
    state_t                  state_q;
    logic [2:0]              cnt_q;

    // Sample memories: independent real/imag write ports, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) begin
                re_mem_q[n] <= '0;
                im_mem_q[n] <= '0;
            end
        end else begin
            if (wr_en_real) re_mem_q[addr_real] <= real_in;
            if (wr_en_imag) im_mem_q[addr_imag] <= imag_in;
        end
    end

    genvar i;
    // Stage 1: pairs (n, n+4) taken in bit-reversed order 0,4,2,6,1,5,3,7
    for (i = 0; i < 4; i++) begin : g_st1
        localparam int AI = ((i & 1) << 1) | (i >> 1);
        fft_bfly #(.IW(IN_W), .OW(S1_W), .MUL(1'b0)) u_bf (
            .a_re_i(re_mem_q[AI]),   .a_im_i(im_mem_q[AI]),
            .b_re_i(re_mem_q[AI+4]), .b_im_i(im_mem_q[AI+4]),
            .tw_i  (2'd0),
            .p_re_o(s1_re[2*i]),     .p_im_o(s1_im[2*i]),
            .q_re_o(s1_re[2*i+1]),   .q_im_o(s1_im[2*i+1])
        );
    end

    // Stage 2: two 4-point DFTs (evens in 0..3, odds in 4..7), twiddles W0/W2
    for (i = 0; i < 4; i++) begin : g_st2
        localparam int AI = (i >> 1) * 4 + (i & 1);
        fft_bfly #(.IW(S1_W), .OW(S2_W), .MUL(1'b0)) u_bf (
            .a_re_i(s1_re[AI]),   .a_im_i(s1_im[AI]),
            .b_re_i(s1_re[AI+2]), .b_im_i(s1_im[AI+2]),
            .tw_i  (2'((i & 1) * 2)),
            .p_re_o(s2_re[AI]),   .p_im_o(s2_im[AI]),
            .q_re_o(s2_re[AI+2]), .q_im_o(s2_im[AI+2])
        );
    end

    // Stage 3: combine evens and odds with W0..W3, result is 256*X[k]
    for (i = 0; i < 4; i++) begin : g_st3
        fft_bfly #(.IW(S2_W), .OW(OUT_W), .MUL(1'b1)) u_bf (
            .a_re_i(s2_re[i]),   .a_im_i(s2_im[i]),
            .b_re_i(s2_re[i+4]), .b_im_i(s2_im[i+4]),
            .tw_i  (2'(i)),
            .p_re_o(x_re[i]),    .p_im_o(x_im[i]),
            .q_re_o(x_re[i+4]),  .q_im_o(x_im[i+4])
        );
    end

    // Control FSM: trigger on the address-7 real write, snapshot, then stream bins
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fft_real_out <= '0;
            fft_imag_out <= '0;
            for (int k = 0; k < 8; k++) begin
                res_re_q[k] <= '0;
                res_im_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en_real && addr_real == 3'd7) state_q <= CALC;
                end
                CALC: begin
                    for (int k = 0; k < 8; k++) begin
                        res_re_q[k] <= x_re[k];
                        res_im_q[k] <= x_im[k];
                    end
                    cnt_q   <= '0;
                    state_q <= OUT;
                end
                OUT: begin
                    fft_real_out <= res_re_q[cnt_q];
                    fft_imag_out <= res_im_q[cnt_q];
                    cnt_q        <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_8pt.sv
// Directed testbench for fft_8pt with hand-computed Q8 bin values.
module tb_fft_8pt;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [11:0] real_in = '0;
    logic signed [11:0] imag_in = '0;
    logic [2:0]         addr_real = '0;
    logic [2:0]         addr_imag = '0;
    logic               wr_en_real = 1'b0;
    logic               wr_en_imag = 1'b0;
    logic signed [23:0] fft_real_out;
    logic signed [23:0] fft_imag_out;

    int checks = 0;
    int errors = 0;
    int vre[8], vim[8], exp_re[8], exp_im[8];
    logic signed [23:0] got_re[8], got_im[8];

    fft_8pt dut (
        .clk         (clk),
        .reset       (reset),
        .real_in     (real_in),
        .imag_in     (imag_in),
        .addr_real   (addr_real),
        .addr_imag   (addr_imag),
        .wr_en_real  (wr_en_real),
        .wr_en_imag  (wr_en_imag),
        .fft_real_out(fft_real_out),
        .fft_imag_out(fft_imag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wr(input int n, input int re, input int im);
        @(negedge clk);
        addr_real = 3'(n); addr_imag = 3'(n);
        real_in = 12'(re); imag_in = 12'(im);
        wr_en_real = 1'b1; wr_en_imag = 1'b1;
        @(posedge clk); #1;
        wr_en_real = 1'b0; wr_en_imag = 1'b0;
    endtask

    // Writes samples 0..7; the address-7 write is the trigger edge T0
    task automatic load_and_trigger();
        for (int n = 0; n < 8; n++) wr(n, vre[n], vim[n]);
    endtask

    // Called at T0+1; samples bin k after edge T0+2+k, optionally writing addr 3 mid-run
    task automatic capture(input int inject_k, input int inj_re);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == inject_k) begin
                @(negedge clk);
                addr_real = 3'd3; addr_imag = 3'd3;
                real_in = 12'(inj_re); imag_in = '0;
                wr_en_real = 1'b1; wr_en_imag = 1'b1;
            end
            @(posedge clk); #1;
            wr_en_real = 1'b0; wr_en_imag = 1'b0;
            got_re[k] = fft_real_out;
            got_im[k] = fft_imag_out;
        end
    endtask

    task automatic set_vec(input int re, input int im);
        for (int n = 0; n < 8; n++) begin vre[n] = re; vim[n] = im; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fft_real_out !== 24'sd0) begin errors++; $display("FAIL reset_real got %0d want 0", fft_real_out); end
        checks++;
        if (fft_imag_out !== 24'sd0) begin errors++; $display("FAIL reset_imag got %0d want 0", fft_imag_out); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_impulse();
        set_vec(0, 0); vre[0] = 1;
        load_and_trigger();
        capture(-1, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_re[k] !== 24'sd256) begin errors++; $display("FAIL impulse_re bin%0d got %0d want 256", k, got_re[k]); end
            checks++;
            if (got_im[k] !== 24'sd0) begin errors++; $display("FAIL impulse_im bin%0d got %0d want 0", k, got_im[k]); end
        end
    endtask

    task automatic test_dc();
        set_vec(1, 0);
        load_and_trigger();
        capture(-1, 0);
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = (k == 0) ? 2048 : 0;
            checks++;
            if (got_re[k] !== 24'(exp_re[k])) begin errors++; $display("FAIL dc_re bin%0d got %0d want %0d", k, got_re[k], exp_re[k]); end
            checks++;
            if (got_im[k] !== 24'sd0) begin errors++; $display("FAIL dc_im bin%0d got %0d want 0", k, got_im[k]); end
        end
    endtask

    task automatic test_shifted_impulse();
        set_vec(0, 0); vre[1] = 100;
        exp_re = '{25600, 18100, 0, -18100, -25600, -18100, 0, 18100};
        exp_im = '{0, -18100, -25600, -18100, 0, 18100, 25600, 18100};
        load_and_trigger();
        capture(-1, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_re[k] !== 24'(exp_re[k])) begin errors++; $display("FAIL shift_re bin%0d got %0d want %0d", k, got_re[k], exp_re[k]); end
            checks++;
            if (got_im[k] !== 24'(exp_im[k])) begin errors++; $display("FAIL shift_im bin%0d got %0d want %0d", k, got_im[k], exp_im[k]); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fft_real_out !== 24'sd18100) begin errors++; $display("FAIL hold_re got %0d want 18100", fft_real_out); end
        checks++;
        if (fft_imag_out !== 24'sd18100) begin errors++; $display("FAIL hold_im got %0d want 18100", fft_imag_out); end
    endtask

    task automatic test_extremes();
        set_vec(-2048, -2048);
        load_and_trigger();
        capture(-1, 0);
        for (int k = 0; k < 8; k++) begin
            exp_re[k] = (k == 0) ? -4194304 : 0;
            checks++;
            if (got_re[k] !== 24'(exp_re[k])) begin errors++; $display("FAIL ext_re bin%0d got %0d want %0d", k, got_re[k], exp_re[k]); end
            checks++;
            if (got_im[k] !== 24'(exp_re[k])) begin errors++; $display("FAIL ext_im bin%0d got %0d want %0d", k, got_im[k], exp_re[k]); end
        end
    endtask

    task automatic test_rewrite();
        set_vec(0, 0); vre[0] = 1;
        load_and_trigger();
        capture(3, 50);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_re[k] !== 24'sd256 || got_im[k] !== 24'sd0)
                begin errors++; $display("FAIL rewrite_hold bin%0d got (%0d,%0d) want (256,0)", k, got_re[k], got_im[k]); end
        end
        wr(7, 0, 0);
        capture(-1, 0);
        exp_re = '{13056, -8794, 256, 9306, -12544, 9306, 256, -8794};
        exp_im = '{0, -9050, 12800, -9050, 0, 9050, -12800, 9050};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_re[k] !== 24'(exp_re[k])) begin errors++; $display("FAIL rerun_re bin%0d got %0d want %0d", k, got_re[k], exp_re[k]); end
            checks++;
            if (got_im[k] !== 24'(exp_im[k])) begin errors++; $display("FAIL rerun_im bin%0d got %0d want %0d", k, got_im[k], exp_im[k]); end
        end
    endtask

    task automatic test_reset_abort();
        set_vec(0, 0); vre[1] = 100;
        load_and_trigger();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        checks++;
        if (fft_real_out !== -24'sd18100) begin errors++; $display("FAIL abort_bin3 got %0d want -18100", fft_real_out); end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (fft_real_out !== 24'sd0 || fft_imag_out !== 24'sd0)
            begin errors++; $display("FAIL abort_clear got (%0d,%0d) want (0,0)", fft_real_out, fft_imag_out); end
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (fft_real_out !== 24'sd0 || fft_imag_out !== 24'sd0)
            begin errors++; $display("FAIL abort_idle got (%0d,%0d) want (0,0)", fft_real_out, fft_imag_out); end
        wr(7, 0, 0);
        capture(-1, 0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got_re[k] !== 24'sd0 || got_im[k] !== 24'sd0)
                begin errors++; $display("FAIL abort_mem bin%0d got (%0d,%0d) want (0,0)", k, got_re[k], got_im[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_shifted_impulse();
        test_extremes();
        test_rewrite();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
